sweep_max_tracker: RTL
======================

Name: sweep_max_tracker

Overview:
- Counter/peak-tracking stage between the light-sensor ADC front end and the calibration FSM.
- During a horizontal or vertical sweep it counts servo steps and records the step index of the brightest ADC sample.
- It then counts the servo back to that index.
- Produces the CNT_L / CNT_RU / CNT_D continuation flags the FSM consumes; consumes the FSM's HS / VS / MC / CNT_RST.

Parameters:
- ADC_W, 12, ADC sample width.
- POS_W, 8, step counter width.
- H_STEPS, 180, horizontal sweep length in steps; range 1..2^POS_W.
- V_STEPS, 90, vertical sweep length in steps; range 1..2^POS_W.
- HYST, 4, improvement margin used only when SWEEP_HYST_EN is defined.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- HS  in  1  horizontal sweep enable from FSM.
- VS  in  1  vertical sweep enable from FSM.
- MC  in  1  return-to-maximum enable from FSM.
- CNT_RST  in  1  synchronous clear from FSM.
- STEP_TICK  in  1  one-cycle strobe per servo step (from PWM stage).
- ADC_DATA  in  ADC_W  light sample.
- ADC_VALID  in  1  ADC_DATA qualifier, one cycle.
- CNT_L  out  1  horizontal sweep still running.
- CNT_RU  out  1  return move still running (horizontal or vertical).
- CNT_D  out  1  vertical sweep still running.
- MAX_VAL  out  ADC_W  peak sample of the current/last sweep.
- H_POS  out  POS_W  horizontal peak step index.
- V_POS  out  POS_W  vertical peak step index.

Behaviour:
- States: IDLE, H_SWEEP, H_RET, V_ARM, V_SWEEP, V_RET, DONE.
- RST low (async): state IDLE; step_cnt, ret_cnt, MAX_VAL, H_POS, V_POS all 0.
- Outputs decoded from state, no register stage:
  - CNT_L = IDLE or H_SWEEP.
  - CNT_D = V_ARM or V_SWEEP.
  - CNT_RU = (H_RET or V_RET) and ret_cnt != 0.
  - CNT_L and CNT_D are high before the FSM enters a sweep, so the FSM never exits a sweep on its first cycle.
- CNT_RST=1: synchronous, highest priority. Forces IDLE and clears all counters and peak registers. Mid-sweep abort follows the same rule.
- IDLE:
  - HS=1 -> H_SWEEP; step_cnt=0, MAX_VAL=0, H_POS=0.
- H_SWEEP:
  - ADC_VALID and ADC_DATA > MAX_VAL (strict) -> MAX_VAL=ADC_DATA, H_POS=step_cnt.
  - Ties keep the earliest position.
  - Capture uses step_cnt before any same-cycle increment.
  - STEP_TICK: step_cnt++.
  - STEP_TICK with step_cnt==H_STEPS-1 -> H_RET; ret_cnt = H_STEPS-1-H_POS, using the H_POS value updated in that same cycle.
- H_RET:
  - MC and STEP_TICK and ret_cnt!=0 -> ret_cnt--.
  - ret_cnt==0 -> V_ARM next cycle. CNT_RU is already low in that cycle.
  - A peak at the final step gives ret_cnt=0: CNT_RU is never asserted.
- V_ARM:
  - VS=1 -> V_SWEEP; step_cnt=0, MAX_VAL=0, V_POS=0.
  - H_POS is retained.
- V_SWEEP / V_RET: same rules as H_SWEEP / H_RET, using V_STEPS and V_POS.
- V_RET with ret_cnt==0 -> DONE.
- DONE:
  - Holds MAX_VAL, H_POS, V_POS; all flags low.
  - Leaves only on CNT_RST.
- Ignored inputs:
  - STEP_TICK in IDLE, V_ARM, DONE.
  - ADC_VALID outside sweep states.
- Counter widths: step_cnt and ret_cnt are POS_W bits and never wrap.

Optional Feature:
- Macro: SWEEP_HYST_EN.
- Defined: update the peak only when ADC_DATA > MAX_VAL + HYST. The comparison is done at ADC_W+1 bits, so there is no overflow. The first valid sample of a sweep always captures.
- Undefined: strict ADC_DATA > MAX_VAL comparison; HYST is unused.

Decomposition:
- Shared package:
  - State encoding typedef (3-bit).
  - Default H_STEPS / V_STEPS.
  - ADC_W / POS_W constants, shared with the PWM and ADC stages.
- Sub-module peak_capture: comparator plus MAX_VAL/position register, with clear, load-enable and the hysteresis option. Instantiated once, with the position source muxed by axis.

Test Plan:
- Reset and idle: RST low mid-sweep -> all outputs 0, state IDLE. After release with CNT_RST=0: CNT_L=1, CNT_RU=0, CNT_D=0.
- Horizontal sweep: H_STEPS=8, samples 10,30,90,40,… per step -> H_POS=2, MAX_VAL=90. CNT_L falls on the 8th tick. CNT_RU stays high for exactly 5 MC ticks, then V_ARM.
- Peak at last step: horizontal peak at step 7 -> CNT_RU never asserted; V_ARM one cycle after H_RET entry.
- Ties: equal values 50 at steps 1 and 4 -> H_POS=1.
- Abort: CNT_RST pulse during V_SWEEP -> IDLE next cycle; H_POS, V_POS, MAX_VAL = 0.
- Hysteresis (SWEEP_HYST_EN, HYST=4): samples 100 then 103 -> MAX_VAL=100. Then 105 -> MAX_VAL=105. Without the macro, 103 captures.

Source files
------------

// File: rtl/sweep_max_tracker_pkg.sv
// Shared constants and state encoding for the sweep peak tracker.
// ADC_W / POS_W are also used by the PWM and ADC front-end stages.
package sweep_max_tracker_pkg;

    localparam int SMT_ADC_W   = 12;
    localparam int SMT_POS_W   = 8;
    localparam int SMT_H_STEPS = 180;
    localparam int SMT_V_STEPS = 90;
    localparam int SMT_HYST    = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_H_SWEEP = 3'd1,
        ST_H_RET   = 3'd2,
        ST_V_ARM   = 3'd3,
        ST_V_SWEEP = 3'd4,
        ST_V_RET   = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

endpackage

// File: rtl/sweep_max_tracker_peak_capture.sv
// Peak comparator with MAX register; o_hit marks a new peak this cycle.
// SWEEP_HYST_EN: require ADC_DATA > MAX + HYST, first valid sample of a sweep always captures.
module peak_capture #(
    parameter int ADC_W = 12,
    parameter int HYST  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_vld,
    input  logic [ADC_W-1:0] i_dat,
    output logic             o_hit,
    output logic [ADC_W-1:0] o_max
);

`ifdef SWEEP_HYST_EN
    localparam bit HYST_ON = 1'b1;
`else
    localparam bit HYST_ON = 1'b0;
`endif
    localparam logic [ADC_W:0] MARGIN = HYST_ON ? (ADC_W+1)'(HYST) : '0;

    logic [ADC_W-1:0] r_max;
    logic             r_seen;
    logic [ADC_W:0]   w_thr;
    logic             w_gt;

    // One extra bit so MAX + margin cannot overflow.
    assign w_thr = {1'b0, r_max} + MARGIN;
    assign w_gt  = (HYST_ON && !r_seen) || ({1'b0, i_dat} > w_thr);
    assign o_hit = i_en && i_vld && w_gt;
    assign o_max = r_max;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_max  <= '0;
            r_seen <= 1'b0;
        end else if (i_clr) begin
            r_max  <= '0;
            r_seen <= 1'b0;
        end else if (o_hit) begin
            r_max  <= i_dat;
            r_seen <= 1'b1;
        end
    end

endmodule

// File: rtl/sweep_max_tracker.sv
// Sweep step counter / peak tracker feeding the calibration FSM (CNT_L/CNT_RU/CNT_D).
// Flags decoded combinationally from state; optional SWEEP_HYST_EN adds peak hysteresis.
module sweep_max_tracker
    import sweep_max_tracker_pkg::*;
#(
    parameter int ADC_W   = SMT_ADC_W,
    parameter int POS_W   = SMT_POS_W,
    parameter int H_STEPS = SMT_H_STEPS,
    parameter int V_STEPS = SMT_V_STEPS,
    parameter int HYST    = SMT_HYST
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             HS,
    input  logic             VS,
    input  logic             MC,
    input  logic             CNT_RST,
    input  logic             STEP_TICK,
    input  logic [ADC_W-1:0] ADC_DATA,
    input  logic             ADC_VALID,
    output logic             CNT_L,
    output logic             CNT_RU,
    output logic             CNT_D,
    output logic [ADC_W-1:0] MAX_VAL,
    output logic [POS_W-1:0] H_POS,
    output logic [POS_W-1:0] V_POS
);

    localparam logic [POS_W-1:0] H_LAST = POS_W'(H_STEPS - 1);
    localparam logic [POS_W-1:0] V_LAST = POS_W'(V_STEPS - 1);

    state_t           r_state;
    logic [POS_W-1:0] r_step_cnt;
    logic [POS_W-1:0] r_ret_cnt;
    logic [POS_W-1:0] r_h_pos;
    logic [POS_W-1:0] r_v_pos;

    logic             w_h_axis;
    logic             w_v_axis;
    logic             w_cap_clr;
    logic             w_hit;
    logic [POS_W-1:0] w_last;
    logic [POS_W-1:0] w_pos_nxt;
    logic [POS_W-1:0] w_ret_init;

    assign w_h_axis  = (r_state == ST_H_SWEEP);
    assign w_v_axis  = (r_state == ST_V_SWEEP);
    assign w_cap_clr = CNT_RST || (r_state == ST_IDLE && HS) || (r_state == ST_V_ARM && VS);
    assign w_last    = w_h_axis ? H_LAST : V_LAST;

    // Return distance must see a peak captured on the very last step.
    assign w_pos_nxt  = w_hit ? r_step_cnt : (w_h_axis ? r_h_pos : r_v_pos);
    assign w_ret_init = w_last - w_pos_nxt;

    peak_capture #(
        .ADC_W (ADC_W),
        .HYST  (HYST)
    ) u_peak (
        .CLK   (CLK),
        .RST   (RST),
        .i_clr (w_cap_clr),
        .i_en  (w_h_axis || w_v_axis),
        .i_vld (ADC_VALID),
        .i_dat (ADC_DATA),
        .o_hit (w_hit),
        .o_max (MAX_VAL)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_IDLE;
            r_step_cnt <= '0;
            r_ret_cnt  <= '0;
            r_h_pos    <= '0;
            r_v_pos    <= '0;
        end else if (CNT_RST) begin
            r_state    <= ST_IDLE;
            r_step_cnt <= '0;
            r_ret_cnt  <= '0;
            r_h_pos    <= '0;
            r_v_pos    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (HS) begin
                        r_state    <= ST_H_SWEEP;
                        r_step_cnt <= '0;
                        r_h_pos    <= '0;
                    end
                end
                ST_H_SWEEP, ST_V_SWEEP: begin
                    if (w_hit) begin
                        if (w_h_axis) r_h_pos <= r_step_cnt;
                        else          r_v_pos <= r_step_cnt;
                    end
                    // Final step leaves the sweep instead of incrementing, so no wrap.
                    if (STEP_TICK) begin
                        if (r_step_cnt == w_last) begin
                            r_state   <= w_h_axis ? ST_H_RET : ST_V_RET;
                            r_ret_cnt <= w_ret_init;
                        end else begin
                            r_step_cnt <= r_step_cnt + 1'b1;
                        end
                    end
                end
                ST_H_RET, ST_V_RET: begin
                    if (r_ret_cnt == '0) begin
                        r_state <= (r_state == ST_H_RET) ? ST_V_ARM : ST_DONE;
                    end else if (MC && STEP_TICK) begin
                        r_ret_cnt <= r_ret_cnt - 1'b1;
                    end
                end
                ST_V_ARM: begin
                    if (VS) begin
                        r_state    <= ST_V_SWEEP;
                        r_step_cnt <= '0;
                        r_v_pos    <= '0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign CNT_L  = (r_state == ST_IDLE) || (r_state == ST_H_SWEEP);
    assign CNT_D  = (r_state == ST_V_ARM) || (r_state == ST_V_SWEEP);
    assign CNT_RU = ((r_state == ST_H_RET) || (r_state == ST_V_RET)) && (r_ret_cnt != '0);
    assign H_POS  = r_h_pos;
    assign V_POS  = r_v_pos;

endmodule
